// File: rtl/mul_seq32_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: FSM encoding and iteration count.
package mul_seq32_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  localparam int         MUL_ITER = 32;
  localparam logic [4:0] CNT_LAST = 5'(MUL_ITER - 1);

endpackage

// File: rtl/cla_32.sv
// 32-bit adder built from 4-bit lookahead groups; group carries skip across each group.
// Purely combinational, no backpressure.
module cla_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] p;
  logic [31:0] g;
  logic        cgrp;
  logic        cbit;
  logic        bg;
  logic        bp;

  always_comb begin
    p    = x ^ y;
    g    = x & y;
    sum  = '0;
    cgrp = cin;
    cbit = 1'b0;
    bg   = 1'b0;
    bp   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bg   = 1'b0;
      bp   = 1'b1;
      cbit = cgrp;
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ cbit;
        cbit       = g[4*k+j] | (p[4*k+j] & cbit);
        bg         = g[4*k+j] | (p[4*k+j] & bg);
        bp         = bp & p[4*k+j];
      end
      // Carry into the next group comes from group G/P, not the in-group ripple.
      cgrp = bg | (bp & cgrp);
    end
    cout = cgrp;
  end

endmodule

// File: rtl/mul_seq32.sv
// Radix-2 shift-and-add unsigned 32x32->64 multiplier; 32 cycles accept-to-valid, II 34.
// Accepts only in IDLE; result held in DONE until res_ready, flush drops everything.
module mul_seq32
  import mul_seq32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] product,
  output logic        busy
);

  mul_state_t  state;
  mul_state_t  state_nxt;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  cnt;
  logic [31:0] addend;
  logic [31:0] sum;
  logic        cout;

  assign addend = lo[0] ? mcand : 32'd0;

  cla_32 u_cla (
    .x    (hi),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MUL_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start_valid)     state_nxt = MUL_RUN;
      MUL_RUN:  if (cnt == CNT_LAST) state_nxt = MUL_DONE;
      MUL_DONE: if (res_ready)       state_nxt = MUL_IDLE;
      default:                       state_nxt = MUL_IDLE;
    endcase
    if (flush) state_nxt = MUL_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (flush) begin
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
    end else begin
      case (state)
        MUL_IDLE: if (start_valid) begin
          mcand <= a;
          lo    <= b;
          hi    <= '0;
          cnt   <= '0;
        end
        MUL_RUN: begin
          // cout is bit 32 of the partial sum and lands in hi[31].
          {hi, lo} <= {cout, sum, lo[31:1]};
          cnt      <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == MUL_IDLE);
  assign res_valid   = (state == MUL_DONE);
  assign busy        = (state == MUL_RUN) || (state == MUL_DONE);
  assign product     = {hi, lo};

endmodule

// File: tb/tb_mul_seq32.sv
// Directed bench for mul_seq32: latency, arithmetic corners, backpressure, reset and flush.
module tb_mul_seq32;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] product;
  logic        busy;

  int checks;
  int errors;

  mul_seq32 dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .product     (product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one operation and wait (bounded) for res_valid; lat=999 on timeout.
  task automatic do_op(input logic [31:0] opa, input logic [31:0] opb, output int lat);
    a           = opa;
    b           = opb;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a           = 32'hDEAD_BEEF;
    b           = 32'hCAFE_F00D;
    lat         = 999;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
    a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL reset_product got %h want 0", product); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    res_ready = 1'b1;
    do_op(32'd3, 32'd5, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency got %0d want 32", lat); end
    checks++; if (product !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL basic_product got %h want f", product); end
    @(posedge clk);
    #1;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_after got %b want 1", start_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", res_valid); end
  endtask

  task automatic test_cout();
    int lat;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (product !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL cout_product got %h want fffffffe00000001", product); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_corners();
    int lat;
    do_op(32'd0, 32'h1234_5678, lat);
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL zero_product got %h want 0", product); end
    @(posedge clk);
    #1;
    do_op(32'h8000_0000, 32'd2, lat);
    checks++; if (product !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL msb_product got %h want 100000000", product); end
    @(posedge clk);
    #1;
    do_op(32'h0001_0001, 32'h0001_0001, lat);
    checks++; if (product !== 64'h0000_0001_0002_0001) begin errors++; $display("FAIL sparse_product got %h want 100020001", product); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat;
    res_ready = 1'b0;
    do_op(32'h10, 32'h10, lat);
    checks++; if (product !== 64'h100) begin errors++; $display("FAIL bp_product got %h want 100", product); end
    for (int i = 0; i < 10; i++) begin
      start_valid = 1'b1;
      a = 32'd1000 + 32'(i);
      b = 32'd77;
      @(posedge clk);
      #1;
      checks++; if (product !== 64'h100) begin errors++; $display("FAIL bp_hold cyc %0d got %h want 100", i, product); end
      checks++; if (start_ready !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b1)
        begin errors++; $display("FAIL bp_flags cyc %0d got sr=%b busy=%b rv=%b want 0 1 1", i, start_ready, busy, res_valid); end
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", start_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_queue got busy %b want 0", busy); end
    checks++; if (product !== 64'h100) begin errors++; $display("FAIL bp_idle_product got %h want 100", product); end
  endtask

  task automatic test_reset_mid();
    int lat;
    a = 32'd100; b = 32'd100; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || start_ready !== 1'b1 || res_valid !== 1'b0)
      begin errors++; $display("FAIL rst_mid_flags got busy=%b sr=%b rv=%b want 0 1 0", busy, start_ready, res_valid); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL rst_mid_product got %h want 0", product); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(32'd7, 32'd6, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL rst_after_latency got %0d want 32", lat); end
    checks++; if (product !== 64'd42) begin errors++; $display("FAIL rst_after_product got %0d want 42", product); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    // Flush during RUN
    a = 32'd55; b = 32'd66; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (start_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_run_idle got sr=%b busy=%b want 1 0", start_ready, busy); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL flush_run_clear got %h want 0", product); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_run_no_result got %0d valid cycles want 0", seen); end
    // Flush in DONE together with a result handshake
    res_ready = 1'b1;
    do_op(32'd12, 32'd12, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL flush_done_reach got %0d want 32", lat); end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL flush_done_idle got sr=%b rv=%b want 1 0", start_ready, res_valid); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL flush_done_clear got %h want 0", product); end
    // Flush together with an accept in IDLE
    a = 32'd3; b = 32'd3; start_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL flush_accept got busy=%b sr=%b want 0 1", busy, start_ready); end
    do_op(32'd9, 32'd9, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL flush_next_latency got %0d want 32", lat); end
    checks++; if (product !== 64'd81) begin errors++; $display("FAIL flush_next_product got %0d want 81", product); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_cout();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
